// File: rtl/key_event_generator.sv
// key_event_generator
//   Turns per-key held levels into one-cycle press, release and typematic
//   auto-repeat pulses. It also produces a registered event encoding (valid,
//   lowest pulsing lane, multi-hit flag) one cycle behind key_pulse.
//
//   Lane map: 0 Enter, 1 F, 2 R, 3 T, 4 W, 5 A, 6 S, 7 D,
//             8 Up, 9 Right, 10 Left, 11 Down.
//
// Ports
//   clk          system clock (single domain)
//   rst          asynchronous active-high reset
//   key_level    held levels, already synchronous to clk
//   repeat_en    per-lane auto-repeat enable
//   key_pulse    one-cycle pulse on press and on each repeat
//   key_release  one-cycle pulse on release
//   key_held     1 while the lane FSM is out of IDLE
//   event_valid  some key_pulse bit was high in the previous cycle
//   event_code   lowest pulsing lane index from the previous cycle
//   event_multi  more than one lane pulsed in the previous cycle

// One key lane: IDLE/DELAY/REPEAT FSM with a shared delay/period counter.
// All outputs are registered.
module key_event_lane #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int CNT_W         = $clog2(REPEAT_DELAY) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic rep_en,
  output logic pulse,
  output logic rel,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } lane_state_t;

  localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_TC = CNT_W'(REPEAT_PERIOD - 1);

  lane_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pulse_nxt, rel_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      rel   <= 1'b0;
      held  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
      rel   <= rel_nxt;
      held  <= (state_nxt != IDLE);
    end
  end

  // Priority inside DELAY/REPEAT: release, then repeat disabled, then
  // terminal count. The counter resets on every transition and stops at its
  // terminal value, so it cannot wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    rel_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (level) begin
          state_nxt = DELAY;
          pulse_nxt = 1'b1;
        end
      end
      DELAY: begin
        if (!level) begin
          state_nxt = IDLE;
          rel_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else if (!rep_en) begin
          cnt_nxt = '0;
        end else if (cnt == DLY_TC) begin
          state_nxt = REPEAT;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!level) begin
          state_nxt = IDLE;
          rel_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else if (!rep_en) begin
          // Re-arm the full initial delay once repeat is re-enabled.
          state_nxt = DELAY;
          cnt_nxt   = '0;
        end else if (cnt == PER_TC) begin
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

module key_event_generator #(
  parameter int NUM_KEYS      = 12,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int CNT_W         = $clog2(REPEAT_DELAY) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_level,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                event_valid,
  output logic [3:0]          event_code,
  output logic                event_multi
);

  // Lanes: one independent FSM per key.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
    key_event_lane #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .CNT_W         (CNT_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .level  (key_level[g]),
      .rep_en (repeat_en[g]),
      .pulse  (key_pulse[g]),
      .rel    (key_release[g]),
      .held   (key_held[g])
    );
  end

  // Encoder: only press/repeat pulses feed it, releases are ignored.
  logic [3:0] code_nxt;
  logic       multi_nxt;

  always_comb begin
    code_nxt = 4'd0;
    // Walk downward so the lowest set index is the one left standing.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_pulse[i]) code_nxt = 4'(i);
    end
    // Clearing the lowest set bit leaves something iff popcount > 1.
    multi_nxt = |(key_pulse & (key_pulse - NUM_KEYS'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_valid <= 1'b0;
      event_code  <= 4'd0;
      event_multi <= 1'b0;
    end else begin
      event_valid <= |key_pulse;
      event_code  <= code_nxt;
      event_multi <= multi_nxt;
    end
  end

endmodule

// File: tb/tb_key_event_generator.sv
// Directed bench for key_event_generator with short repeat timing
// (REPEAT_DELAY=8, REPEAT_PERIOD=4). Outputs are sampled 1 time unit after
// each rising edge.
module tb_key_event_generator;

  localparam int NK = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_level;
  logic [NK-1:0] repeat_en;
  logic [NK-1:0] key_pulse, key_release, key_held;
  logic          event_valid, event_multi;
  logic [3:0]    event_code;

  int vecs = 0;
  int errs = 0;

  key_event_generator #(
    .NUM_KEYS      (NK),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_level   (key_level),
    .repeat_en   (repeat_en),
    .key_pulse   (key_pulse),
    .key_release (key_release),
    .key_held    (key_held),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_multi (event_multi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit p_exp, c_exp;

    // Reset with every key held.
    rst       = 1'b1;
    key_level = 12'hFFF;
    repeat_en = 12'hFFF;
    tick();
    chk("rst_pulse",   32'(key_pulse),   32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    chk("rst_held",    32'(key_held),    32'h0);
    chk("rst_valid",   32'(event_valid), 32'h0);
    chk("rst_code",    32'(event_code),  32'h0);
    chk("rst_multi",   32'(event_multi), 32'h0);

    rst = 1'b0;
    tick();
    chk("rel_all_pulse", 32'(key_pulse), 32'hFFF);
    chk("rel_all_held",  32'(key_held),  32'hFFF);
    chk("rel_all_valid", 32'(event_valid), 32'h0);
    tick();
    chk("all_pulse_off", 32'(key_pulse),   32'h0);
    chk("all_valid",     32'(event_valid), 32'h1);
    chk("all_code",      32'(event_code),  32'h0);
    chk("all_multi",     32'(event_multi), 32'h1);
    key_level = '0;
    tick();
    chk("all_release", 32'(key_release), 32'hFFF);
    chk("all_held0",   32'(key_held),    32'h0);
    tick();
    chk("all_release_off", 32'(key_release), 32'h0);
    chk("all_valid_off",   32'(event_valid), 32'h0);

    // Auto-repeat on A: 20 edges held. Press at t=0, repeats at t=8,12,16,
    // release at t=20; encoder follows one tick later.
    key_level[5] = 1'b1;
    for (int t = 0; t < 22; t++) begin
      if (t == 20) key_level[5] = 1'b0;
      if (t > 0) begin end
      tick();
      p_exp = (t == 0 || t == 8 || t == 12 || t == 16);
      chk($sformatf("a_pulse_t%0d", t), 32'(key_pulse), p_exp ? 32'h20 : 32'h0);
      chk($sformatf("a_rel_t%0d", t), 32'(key_release), (t == 20) ? 32'h20 : 32'h0);
      chk($sformatf("a_held_t%0d", t), 32'(key_held), (t < 20) ? 32'h20 : 32'h0);
      c_exp = (t == 1 || t == 9 || t == 13 || t == 17);
      chk($sformatf("a_valid_t%0d", t), 32'(event_valid), 32'(c_exp));
      if (c_exp) chk($sformatf("a_code_t%0d", t), 32'(event_code), 32'd5);
    end

    // repeat_en off: W held 40 edges gives one press and one release.
    repeat_en = '0;
    key_level[4] = 1'b1;
    for (int t = 0; t < 42; t++) begin
      if (t == 40) key_level[4] = 1'b0;
      tick();
      chk($sformatf("w_pulse_t%0d", t), 32'(key_pulse), (t == 0) ? 32'h10 : 32'h0);
      chk($sformatf("w_rel_t%0d", t), 32'(key_release), (t == 40) ? 32'h10 : 32'h0);
      chk($sformatf("w_held_t%0d", t), 32'(key_held), (t < 40) ? 32'h10 : 32'h0);
    end
    repeat_en = 12'hFFF;

    // Up and Left pressed together.
    key_level = 12'h500;
    tick();
    chk("ul_pulse", 32'(key_pulse), 32'h500);
    tick();
    chk("ul_pulse_off", 32'(key_pulse),   32'h0);
    chk("ul_valid",     32'(event_valid), 32'h1);
    chk("ul_code",      32'(event_code),  32'd8);
    chk("ul_multi",     32'(event_multi), 32'h1);
    key_level = '0;
    tick();
    chk("ul_release", 32'(key_release), 32'h500);
    tick();

    // One-cycle glitch on Enter.
    key_level[0] = 1'b1;
    tick();
    chk("gl_pulse",    32'(key_pulse),   32'h1);
    chk("gl_rel0",     32'(key_release), 32'h0);
    key_level[0] = 1'b0;
    tick();
    chk("gl_pulse_off", 32'(key_pulse),   32'h0);
    chk("gl_release",   32'(key_release), 32'h1);
    chk("gl_held",      32'(key_held),    32'h0);
    chk("gl_valid",     32'(event_valid), 32'h1);
    chk("gl_code",      32'(event_code),  32'h0);
    chk("gl_multi",     32'(event_multi), 32'h0);
    for (int t = 0; t < 10; t++) begin
      tick();
      chk($sformatf("gl_quiet_t%0d", t), 32'({key_pulse, key_release}), 32'h0);
    end

    // Mid-hold asynchronous reset on D while in REPEAT.
    key_level[7] = 1'b1;
    for (int t = 0; t < 11; t++) tick();
    chk("d_held", 32'(key_held), 32'h80);
    #2 rst = 1'b1;
    #1;
    chk("d_async_held",  32'(key_held),    32'h0);
    chk("d_async_rel",   32'(key_release), 32'h0);
    chk("d_async_pulse", 32'(key_pulse),   32'h0);
    tick();
    chk("d_rst_rel",   32'(key_release), 32'h0);
    rst = 1'b0;
    tick();
    chk("d_repress", 32'(key_pulse),   32'h80);
    chk("d_rel_no",  32'(key_release), 32'h0);
    chk("d_held2",   32'(key_held),    32'h80);
    key_level[7] = 1'b0;
    tick();
    chk("d_release", 32'(key_release), 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/key_event_generator.md
# key_event_generator

Converts the per-key level signals from the keyboard control stage (Enter, F, R, T, W, A, S, D, Up, Right, Left, Down) into one-cycle press pulses, release pulses and typematic auto-repeat pulses. It also outputs a single encoded event (valid + key code) for menu and game-state logic. It sits directly downstream of the keyboard control stage, in the same `clk` domain, and feeds the arcade game FSMs.

## Interface
- `NUM_KEYS`, 12: number of key lanes. Fixed mapping: 0 Enter, 1 F, 2 R, 3 T, 4 W, 5 A, 6 S, 7 D, 8 Up, 9 Right, 10 Left, 11 Down.
- `REPEAT_DELAY`, 50_000_000: cycles from the press pulse to the first repeat pulse. Must be ≥2.
- `REPEAT_PERIOD`, 10_000_000: cycles between consecutive repeat pulses. Must be ≥2.
- `CNT_W`, `$clog2(REPEAT_DELAY)+1`: per-lane counter width. Must hold max(REPEAT_DELAY, REPEAT_PERIOD).
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: asynchronous, active-high reset.
- `key_level` in NUM_KEYS: key held levels from keyboard control. Already synchronous to `clk`.
- `repeat_en` in NUM_KEYS: per-lane auto-repeat enable.
- `key_pulse` out NUM_KEYS: one-cycle pulse on a press and on each repeat.
- `key_release` out NUM_KEYS: one-cycle pulse on release.
- `key_held` out NUM_KEYS: registered copy of the held state (1 when the lane FSM is not IDLE).
- `event_valid` out 1: one-cycle flag; at least one `key_pulse` was high in the previous cycle.
- `event_code` out 4: index of the lowest-numbered lane pulsing in the previous cycle.
- `event_multi` out 1: more than one lane was pulsing in the previous cycle.

## Operation
- Each lane has an independent FSM with states IDLE, DELAY and REPEAT, plus a CNT_W-bit counter `cnt`.
- All lane decisions use `key_level[i]` and `repeat_en[i]` sampled at the same rising edge.
- IDLE:
  - level=1: go to DELAY, cnt←0, `key_pulse[i]`←1.
  - Otherwise: stay in IDLE.
- DELAY:
  - level=0: go to IDLE, `key_release[i]`←1, cnt←0.
  - repeat_en=0: stay in DELAY, cnt←0, no pulse.
  - cnt==REPEAT_DELAY-1: go to REPEAT, cnt←0, `key_pulse[i]`←1.
  - Otherwise: cnt←cnt+1.
- REPEAT:
  - level=0: go to IDLE, `key_release[i]`←1, cnt←0.
  - repeat_en=0: go to DELAY, cnt←0.
  - cnt==REPEAT_PERIOD-1: cnt←0, `key_pulse[i]`←1.
  - Otherwise: cnt←cnt+1.
- Priority within a lane: release, then repeat_en=0, then the terminal count.
- Counter arithmetic is unsigned. It never exceeds its terminal value, so it never wraps.
- `key_pulse` and `key_release` are registered. Each is high for exactly one cycle per event. They are never both high on the same lane in the same cycle.
- `key_held[i]` is 1 in DELAY and REPEAT, and 0 in IDLE.
- Encoder stage (registered, one cycle after `key_pulse`):
  - `event_valid` = OR of `key_pulse`.
  - `event_code` = priority-encoded lowest set index of `key_pulse`, or 0 when none is set.
  - `event_multi` = popcount(`key_pulse`) > 1.
  - Release events do not drive the encoder.
- Lanes are fully independent. Simultaneous presses on several lanes each pulse in the same cycle.

## Timing
- Reset values: all lane FSMs IDLE, all cnt 0, and all outputs 0 (`key_pulse`, `key_release`, `key_held`, `event_valid`, `event_code`=4'd0, `event_multi`).
- Reset is asynchronous. Asserting `rst` mid-hold clears the lane immediately with no release pulse. After `rst` deasserts with the key still held, the next edge produces a fresh press pulse.
- Press latency: level first sampled 1 at edge N → `key_pulse` high in cycle N+1 (after edge N, until edge N+1).
- First repeat pulse: exactly REPEAT_DELAY cycles after the press pulse. Later repeats: every REPEAT_PERIOD cycles.
- Release latency: level first sampled 0 at edge M → `key_release` high in cycle M+1. No repeat pulse in that cycle.
- Encoder latency: `event_*` lag `key_pulse` by exactly one cycle, so they are 2 cycles after the input edge.
- A one-cycle level pulse (high at edge N, low at edge N+1) gives a press pulse in cycle N+1 and a release pulse in cycle N+2.
- repeat_en deasserted then reasserted while held: the first repeat comes REPEAT_DELAY cycles after the first edge that samples repeat_en=1.

## Test plan
- Reset: `rst` high with `key_level`=12'hFFF → all outputs 0. Release `rst` → `key_pulse`=12'hFFF one cycle later, then `event_valid`=1, `event_code`=0, `event_multi`=1.
- Auto-repeat (REPEAT_DELAY=8, REPEAT_PERIOD=4, repeat_en all 1): A (bit 5) high at edges 10–29 → `key_pulse[5]` in cycles 11, 19, 23, 27 only; `key_release[5]` in cycle 31; `event_code`=5 in cycles 12, 20, 24, 28.
- repeat_en=0: hold W (bit 4) for 40 cycles → exactly one press pulse and one release pulse; `key_held[4]` high for 40 cycles.
- Simultaneous presses: Up (bit 8) and Left (bit 10) rise at the same edge → both pulse in the same cycle; next cycle `event_code`=8, `event_multi`=1.
- One-cycle glitch: Enter high for a single edge → press pulse then release pulse in consecutive cycles; no repeat.
- Mid-hold reset: assert `rst` during REPEAT on D (bit 7) → `key_held[7]` drops without waiting for a clock edge and no release pulse occurs. Deassert `rst` with D still held → press pulse on the next cycle.
